mac_column: RTL and testbench

Parametrised weight-stationary systolic MAC column, successor to the single-PE `mac`. It stacks NUM_ROWS processing elements. Partial sums flow down the column, and ifmaps pass through each row to the next column. Weights are double-buffered through a serial shadow chain, so a new weight set loads while the column computes. It adds signed/unsigned mode, optional saturation and a valid pipeline, and forms the column tile of the systolic array.

---
 rtl/mac_pkg.sv | 44 ++++
 rtl/mac_column_if.sv | 34 +++
 rtl/mac_pe.sv | 76 +++++++
 rtl/mac_column.sv | 63 ++++++
 tb/tb_mac_column.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared constants and the accumulate-result clamp/wrap helper for the MAC family.
package mac_pkg;

    localparam int unsigned IFMAP_WIDTH_DEF  = 8;
    localparam int unsigned WEIGHT_WIDTH_DEF = 8;
    localparam int unsigned OFMAP_WIDTH_DEF  = 24;
    localparam int unsigned NUM_ROWS_DEF     = 4;

    // Widest accumulator the helper supports; callers sign/zero-extend into MAX_W+1 bits.
    localparam int unsigned MAX_W = 64;

    // Clamp (saturate=1) or truncate (saturate=0) an extended sum to 'width' bits.
    function automatic logic [MAX_W-1:0] sat_trunc(
        input logic [MAX_W:0] sum,
        input int unsigned    width,
        input logic           is_signed,
        input logic           saturate
    );
        logic [MAX_W:0] one;
        logic [MAX_W:0] hi;
        logic [MAX_W:0] lo;
        one       = (MAX_W+1)'(1);
        hi        = '0;
        lo        = '0;
        sat_trunc = sum[MAX_W-1:0];
        if (saturate) begin
            if (is_signed) begin
                hi = (one << (width - 1)) - one;
                lo = ~hi;
                if ($signed(sum) > $signed(hi)) begin
                    sat_trunc = hi[MAX_W-1:0];
                end else if ($signed(sum) < $signed(lo)) begin
                    sat_trunc = lo[MAX_W-1:0];
                end
            end else begin
                hi = (one << width) - one;
                if (sum > hi) begin
                    sat_trunc = hi[MAX_W-1:0];
                end
            end
        end
    endfunction

endpackage

// File: rtl/mac_column_if.sv
// Column-level bus: control, serial weight load, ifmap/psum data in and out.
interface mac_column_if
    import mac_pkg::*;
#(
    parameter int unsigned IFMAP_WIDTH  = IFMAP_WIDTH_DEF,
    parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    parameter int unsigned OFMAP_WIDTH  = OFMAP_WIDTH_DEF,
    parameter int unsigned NUM_ROWS     = NUM_ROWS_DEF
);

    logic                            enable;
    logic                            in_valid;
    logic                            weight_shift_enable;
    logic                            weight_swap;
    logic [WEIGHT_WIDTH-1:0]         weight_in;
    logic [NUM_ROWS*IFMAP_WIDTH-1:0] ifmap_in;
    logic [OFMAP_WIDTH-1:0]          ofmap_in;
    logic [NUM_ROWS*IFMAP_WIDTH-1:0] ifmap_out;
    logic [OFMAP_WIDTH-1:0]          ofmap_out;
    logic                            out_valid;

    modport master (
        output enable, in_valid, weight_shift_enable, weight_swap,
               weight_in, ifmap_in, ofmap_in,
        input  ifmap_out, ofmap_out, out_valid
    );

    modport slave (
        input  enable, in_valid, weight_shift_enable, weight_swap,
               weight_in, ifmap_in, ofmap_in,
        output ifmap_out, ofmap_out, out_valid
    );

endinterface

// File: rtl/mac_pe.sv
// One weight-stationary PE row: shadow/active weights, MAC with clamp/wrap, psum/ifmap/valid regs.
module mac_pe
    import mac_pkg::*;
#(
    parameter int unsigned IFMAP_WIDTH  = IFMAP_WIDTH_DEF,
    parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    parameter int unsigned OFMAP_WIDTH  = OFMAP_WIDTH_DEF,
    parameter int unsigned SIGNED       = 1,
    parameter int unsigned SATURATE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    weight_shift_enable,
    input  logic                    weight_swap,
    input  logic [WEIGHT_WIDTH-1:0] shadow_in,
    output logic [WEIGHT_WIDTH-1:0] shadow_out,
    input  logic [IFMAP_WIDTH-1:0]  ifmap_in,
    output logic [IFMAP_WIDTH-1:0]  ifmap_out,
    input  logic [OFMAP_WIDTH-1:0]  psum_in,
    output logic [OFMAP_WIDTH-1:0]  psum_out,
    input  logic                    valid_in,
    output logic                    valid_out
);

    localparam int unsigned PROD_W = IFMAP_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned SUM_W  = OFMAP_WIDTH + 1;
    localparam logic        SGN    = (SIGNED != 0);
    localparam logic        SAT    = (SATURATE != 0);

    logic [WEIGHT_WIDTH-1:0] shadow;
    logic [WEIGHT_WIDTH-1:0] active;
    logic [PROD_W-1:0]       op_a;
    logic [PROD_W-1:0]       op_b;
    logic [PROD_W-1:0]       prod;
    logic [SUM_W-1:0]        sum;
    logic [MAX_W:0]          sum_wide;
    logic [OFMAP_WIDTH-1:0]  psum_next;

    assign shadow_out = shadow;

    // Operands extended to product width so the low PROD_W bits are the exact product.
    always_comb begin
        op_a      = {{WEIGHT_WIDTH{SGN & ifmap_in[IFMAP_WIDTH-1]}}, ifmap_in};
        op_b      = {{IFMAP_WIDTH{SGN & active[WEIGHT_WIDTH-1]}}, active};
        prod      = op_a * op_b;
        sum       = {{(SUM_W-PROD_W){SGN & prod[PROD_W-1]}}, prod}
                  + {SGN & psum_in[OFMAP_WIDTH-1], psum_in};
        sum_wide  = {{(MAX_W+1-SUM_W){SGN & sum[SUM_W-1]}}, sum};
        psum_next = OFMAP_WIDTH'(sat_trunc(sum_wide, OFMAP_WIDTH, SGN, SAT));
    end

    // Weight path ignores enable; a swap captures the shadow value from before any same-cycle shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (weight_shift_enable) shadow <= shadow_in;
            if (weight_swap)         active <= shadow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_out  <= '0;
            ifmap_out <= '0;
            valid_out <= 1'b0;
        end else if (enable) begin
            psum_out  <= psum_next;
            ifmap_out <= ifmap_in;
            valid_out <= valid_in;
        end
    end

endmodule

// File: rtl/mac_column.sv
// Weight-stationary systolic column: NUM_ROWS chained PEs, psum flowing down, serial weight load.
module mac_column
    import mac_pkg::*;
#(
    parameter int unsigned IFMAP_WIDTH  = IFMAP_WIDTH_DEF,
    parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    parameter int unsigned OFMAP_WIDTH  = OFMAP_WIDTH_DEF,
    parameter int unsigned NUM_ROWS     = NUM_ROWS_DEF,
    parameter int unsigned SIGNED       = 1,
    parameter int unsigned SATURATE     = 0
) (
    input logic         clk,
    input logic         rst_n,
    mac_column_if.slave bus
);

    logic [WEIGHT_WIDTH-1:0] shadow [NUM_ROWS];
    logic [OFMAP_WIDTH-1:0]  psum   [NUM_ROWS];
    logic                    valid  [NUM_ROWS];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        logic [WEIGHT_WIDTH-1:0] shadow_prev;
        logic [OFMAP_WIDTH-1:0]  psum_prev;
        logic                    valid_prev;

        // Row 0 is fed from the column inputs, later rows from the row above.
        if (r == 0) begin : g_head
            assign shadow_prev = bus.weight_in;
            assign psum_prev   = bus.ofmap_in;
            assign valid_prev  = bus.in_valid;
        end else begin : g_body
            assign shadow_prev = shadow[r-1];
            assign psum_prev   = psum[r-1];
            assign valid_prev  = valid[r-1];
        end

        mac_pe #(
            .IFMAP_WIDTH (IFMAP_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .OFMAP_WIDTH (OFMAP_WIDTH),
            .SIGNED      (SIGNED),
            .SATURATE    (SATURATE)
        ) u_pe (
            .clk                (clk),
            .rst_n              (rst_n),
            .enable             (bus.enable),
            .weight_shift_enable(bus.weight_shift_enable),
            .weight_swap        (bus.weight_swap),
            .shadow_in          (shadow_prev),
            .shadow_out         (shadow[r]),
            .ifmap_in           (bus.ifmap_in[r*IFMAP_WIDTH +: IFMAP_WIDTH]),
            .ifmap_out          (bus.ifmap_out[r*IFMAP_WIDTH +: IFMAP_WIDTH]),
            .psum_in            (psum_prev),
            .psum_out           (psum[r]),
            .valid_in           (valid_prev),
            .valid_out          (valid[r])
        );
    end

    assign bus.ofmap_out = psum[NUM_ROWS-1];
    assign bus.out_valid = valid[NUM_ROWS-1];

endmodule

// File: tb/tb_mac_column.sv
// Drives four signedness/saturation variants of mac_column with shared stimulus against a history-based model.
module tb_mac_column;

    localparam int unsigned IW   = 4;
    localparam int unsigned WW   = 4;
    localparam int unsigned OW   = 8;
    localparam int unsigned NR   = 4;
    localparam int unsigned NCFG = 4;

    // Config c: 0 signed/wrap, 1 signed/sat, 2 unsigned/sat, 3 unsigned/wrap
    function automatic bit cfg_signed(input int c); return (c < 2); endfunction
    function automatic bit cfg_sat(input int c);    return (c == 1) || (c == 2); endfunction

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 in_valid;
    logic                 shift;
    logic                 swap;
    logic [WW-1:0]        weight_in;
    logic [NR*IW-1:0]     ifmap_in;
    logic [OW-1:0]        ofmap_in;

    logic [OW-1:0]        ofm [NCFG];
    logic                 vld [NCFG];
    logic [NR*IW-1:0]     ifo [NCFG];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int unsigned SG = (c < 2) ? 1 : 0;
        localparam int unsigned ST = (c == 1 || c == 2) ? 1 : 0;

        mac_column_if #(.IFMAP_WIDTH(IW), .WEIGHT_WIDTH(WW), .OFMAP_WIDTH(OW), .NUM_ROWS(NR)) bus ();

        assign bus.enable              = enable;
        assign bus.in_valid            = in_valid;
        assign bus.weight_shift_enable = shift;
        assign bus.weight_swap         = swap;
        assign bus.weight_in           = weight_in;
        assign bus.ifmap_in            = ifmap_in;
        assign bus.ofmap_in            = ofmap_in;

        mac_column #(
            .IFMAP_WIDTH(IW), .WEIGHT_WIDTH(WW), .OFMAP_WIDTH(OW), .NUM_ROWS(NR),
            .SIGNED(SG), .SATURATE(ST)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        assign ofm[c] = bus.ofmap_out;
        assign vld[c] = bus.out_valid;
        assign ifo[c] = bus.ifmap_out;
    end

    // Model state: one history entry per enabled edge, holding that cycle's inputs and active weights.
    typedef struct packed {
        logic [NR-1:0][IW-1:0] ifm;
        logic [OW-1:0]         ofm_in;
        logic                  vld;
        logic [NR-1:0][WW-1:0] w;
    } entry_t;

    entry_t                hist [$];
    logic [NR-1:0][WW-1:0] m_shadow;
    logic [NR-1:0][WW-1:0] m_active;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_shadow = '0;
            m_active = '0;
        end else begin
            if (enable) begin
                entry_t e;
                e.ifm    = ifmap_in;
                e.ofm_in = ofmap_in;
                e.vld    = in_valid;
                e.w      = m_active;
                hist.push_back(e);
            end
            if (swap)  m_active = m_shadow;
            if (shift) m_shadow = {m_shadow[NR-2:0], weight_in};
        end
    end

    function automatic longint as_int(input logic [63:0] v, input int w, input bit sg);
        longint m;
        longint x;
        m = longint'(1) << w;
        x = longint'(v) & (m - 1);
        if (sg && x >= (m >> 1)) x = x - m;
        return x;
    endfunction

    function automatic longint f_acc(input longint v, input bit sg, input bit st);
        longint m;
        longint lo;
        longint hi;
        longint x;
        m = longint'(1) << OW;
        if (st) begin
            lo = sg ? -(m >> 1) : 0;
            hi = sg ? (m >> 1) - 1 : m - 1;
            return (v > hi) ? hi : ((v < lo) ? lo : v);
        end
        x = ((v % m) + m) % m;
        if (sg && x >= (m >> 1)) x = x - m;
        return x;
    endfunction

    // Result of vector k: row r consumed its skewed input and active weight on enabled edge k+r.
    function automatic logic [OW-1:0] model_ofm(input int c, input int k);
        bit     sg;
        bit     st;
        longint acc;
        sg  = cfg_signed(c);
        st  = cfg_sat(c);
        acc = as_int(64'(hist[k].ofm_in), OW, sg);
        for (int r = 0; r < NR; r++) begin
            acc = f_acc(acc + as_int(64'(hist[k+r].ifm[r]), IW, sg)
                            * as_int(64'(hist[k+r].w[r]), WW, sg), sg, st);
        end
        return OW'(acc);
    endfunction

    task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d at %0t: got 0x%0h expected 0x%0h", name, c, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every variant against the model.
    always @(negedge clk) begin
        int n;
        n = hist.size();
        for (int c = 0; c < NCFG; c++) begin
            logic exp_v;
            exp_v = (n >= NR) ? hist[n-NR].vld : 1'b0;
            check("out_valid", c, 64'(vld[c]), 64'(exp_v));
            check("ifmap_out", c, 64'(ifo[c]), (n >= 1) ? 64'(hist[n-1].ifm) : 64'(0));
            if (exp_v) check("ofmap_out", c, 64'(ofm[c]), 64'(model_ofm(c, n - NR)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable    = 1'b1;
        in_valid  = 1'b0;
        shift     = 1'b0;
        swap      = 1'b0;
        weight_in = '0;
        ifmap_in  = '0;
        ofmap_in  = '0;
    endtask

    task automatic load_weights(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                input logic [WW-1:0] w2, input logic [WW-1:0] w3);
        logic [NR-1:0][WW-1:0] ws;
        ws = {w3, w2, w1, w0};
        for (int i = 0; i < NR; i++) begin
            weight_in = ws[i];
            shift     = 1'b1;
            tick();
        end
        shift = 1'b0;
        swap  = 1'b1;
        tick();
        swap  = 1'b0;
    endtask

    // One skewed vector; optional 3-cycle enable drop before skew step stall_at (-1 for none).
    task automatic send_one(input logic [IW-1:0] x, input logic [OW-1:0] pin, input int stall_at);
        for (int r = 0; r < NR; r++) begin
            if (r == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    enable   = 1'b0;
                    ifmap_in = (NR*IW)'($urandom);
                    ofmap_in = OW'($urandom);
                    in_valid = 1'b1;
                    tick();
                end
                enable = 1'b1;
            end
            ifmap_in                = '0;
            ifmap_in[r*IW +: IW]    = x;
            in_valid                = (r == 0);
            ofmap_in                = (r == 0) ? pin : '0;
            tick();
        end
        idle();
    endtask

    task automatic expect_all(input string name, input logic [NCFG-1:0][OW-1:0] exp);
        for (int c = 0; c < NCFG; c++) begin
            check({name, "_valid"}, c, 64'(vld[c]), 64'(1));
            check(name, c, 64'(ofm[c]), 64'(exp[c]));
        end
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        for (int c = 0; c < NCFG; c++) begin
            check("reset_ofmap", c, 64'(ofm[c]), 64'(0));
            check("reset_valid", c, 64'(vld[c]), 64'(0));
            check("reset_ifmap", c, 64'(ifo[c]), 64'(0));
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Weights [4,3,2,1] on rows 0..3, ifmap 1 everywhere: 4+3+2+1
        load_weights(4'd1, 4'd2, 4'd3, 4'd4);
        send_one(4'd1, 8'd0, -1);
        expect_all("load_sum", {8'd10, 8'd10, 8'd10, 8'd10});

        // -1 weights, ifmap 3: signed -12; unsigned reads 15*3*4 = 180
        load_weights(4'hF, 4'hF, 4'hF, 4'hF);
        send_one(4'd3, 8'd0, -1);
        expect_all("neg_weights", {8'hB4, 8'hB4, 8'hF4, 8'hF4});

        // 100 + 4*49: signed sat 127, unsigned sat 255, wrap 296 mod 256 = 40
        load_weights(4'd7, 4'd7, 4'd7, 4'd7);
        send_one(4'd7, 8'd100, -1);
        expect_all("saturate", {8'd40, 8'd255, 8'd127, 8'd40});

        // Shadow [4,3,2,1]; shift 9 together with swap must activate the pre-shift set
        load_weights(4'd1, 4'd2, 4'd3, 4'd4);
        weight_in = 4'd9;
        shift     = 1'b1;
        swap      = 1'b1;
        tick();
        idle();
        send_one(4'd1, 8'd0, -1);
        expect_all("swap_preshift", {8'd10, 8'd10, 8'd10, 8'd10});

        // Now active [9,4,3,2]: signed -7+4+3+2 = 2, unsigned 18
        swap = 1'b1;
        tick();
        swap = 1'b0;
        send_one(4'd1, 8'd0, -1);
        expect_all("swap_new_set", {8'd18, 8'd18, 8'd2, 8'd2});

        // Same vector with a 3-cycle stall between skew steps; result is unchanged
        send_one(4'd1, 8'd5, 2);
        expect_all("stall", {8'd23, 8'd23, 8'd7, 8'd7});

        // Asynchronous reset mid-stream clears outputs immediately and both weight sets
        in_valid = 1'b1;
        ifmap_in = 16'h5555;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < NCFG; c++) begin
            check("midreset_ofmap", c, 64'(ofm[c]), 64'(0));
            check("midreset_valid", c, 64'(vld[c]), 64'(0));
            check("midreset_ifmap", c, 64'(ifo[c]), 64'(0));
        end
        tick();
        rst_n = 1'b1;
        idle();
        swap = 1'b1;
        tick();
        swap = 1'b0;
        send_one(4'd5, 8'd9, -1);
        expect_all("zero_weights", {8'd9, 8'd9, 8'd9, 8'd9});

        // Randomized stream with stalls, weight shifts and swaps, and one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 9) < 8);
            in_valid  = 1'($urandom_range(0, 1));
            ifmap_in  = (NR*IW)'($urandom);
            ofmap_in  = OW'($urandom);
            shift     = ($urandom_range(0, 3) == 0);
            swap      = ($urandom_range(0, 15) == 0);
            weight_in = WW'($urandom);
            if (i == 1500) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        idle();
        for (int i = 0; i < NR + 2; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
